// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
// Purpose: FSM state encoding and core-index sizing shared by the arbiter and its
//          round-robin picker. No ports.
package dmem_arbiter_pkg;

  localparam int CORE_ID_W = 3;
  localparam int MAX_CORES = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rtl/dmem_arbiter_rr_pick.sv - combinational rotate-priority encoder
// Purpose: returns the first requesting core found searching upward from ptr,
//          wrapping CORES-1 -> 0.
// Ports:
//   req   in  CORES      request vector
//   ptr   in  CORE_ID_W  highest-priority core index (must be < CORES)
//   valid out 1          any request present
//   idx   out CORE_ID_W  winning core index (0 when no request)
import dmem_arbiter_pkg::*;

module dmem_arbiter_rr_pick #(
  parameter int CORES = 4
) (
  input  logic [CORES-1:0]     req,
  input  logic [CORE_ID_W-1:0] ptr,
  output logic                 valid,
  output logic [CORE_ID_W-1:0] idx
);

  logic [MAX_CORES-1:0] req_ext;
  logic [CORE_ID_W:0]   cand;

  // Walk offsets from farthest to nearest so the nearest requester, which is
  // assigned last, ends up as the winner.
  always_comb begin
    req_ext = MAX_CORES'(req);
    valid   = |req;
    idx     = '0;
    cand    = '0;
    for (int off = CORES - 1; off >= 0; off--) begin
      cand = {1'b0, ptr} + (CORE_ID_W + 1)'(off);
      if (cand >= (CORE_ID_W + 1)'(CORES)) begin
        cand = cand - (CORE_ID_W + 1)'(CORES);
      end
      if (req_ext[cand[CORE_ID_W-1:0]]) begin
        idx = cand[CORE_ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin front end sharing one single-port data RAM
// Purpose: serialises per-core requests onto one RAM; each transaction takes
//          IDLE -> ACCESS -> DONE (3 cycles).
// Ports:
//   Clk, Rst_n   clock, asynchronous active-low reset
//   core_req     in  CORES        per-core request, held until core_done
//   core_we      in  CORES        per-core write select
//   core_addr    in  CORES*WIDTH  per-core address, core i at [i*WIDTH +: WIDTH]
//   core_wdata   in  CORES*WIDTH  per-core write data, same packing
//   core_done    out CORES        one-cycle completion pulse to the served core
//   core_rdata   out WIDTH        read data, valid while core_done pulses for a read
//   mem_en/we/addr/wdata out      RAM access, non-zero only in ACCESS
//   mem_rdata    in  WIDTH        RAM read data, valid the cycle after mem_en
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
  parameter int WIDTH = 8,
  parameter int CORES = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [CORES-1:0]       core_req,
  input  logic [CORES-1:0]       core_we,
  input  logic [CORES*WIDTH-1:0] core_addr,
  input  logic [CORES*WIDTH-1:0] core_wdata,
  output logic [CORES-1:0]       core_done,
  output logic [WIDTH-1:0]       core_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [WIDTH-1:0]       mem_addr,
  output logic [WIDTH-1:0]       mem_wdata,
  input  logic [WIDTH-1:0]       mem_rdata
);

  state_t               state, state_nxt;
  logic [CORE_ID_W-1:0] rr_ptr;
  logic [CORE_ID_W-1:0] idx;
  logic                 lat_we;
  logic [WIDTH-1:0]     lat_addr;
  logic [WIDTH-1:0]     lat_wdata;
  logic [WIDTH-1:0]     rdata_q;
  logic                 pick_valid;
  logic [CORE_ID_W-1:0] pick_idx;
  logic                 grant;

  dmem_arbiter_rr_pick #(.CORES(CORES)) u_pick (
    .req   (core_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign grant = (state == ST_IDLE) && pick_valid;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RAM strobes are decoded from state so an asynchronous reset removes
  // mem_en immediately. core_rdata passes mem_rdata through during a read
  // DONE so it is valid alongside core_done, and is held from rdata_q after.
  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_done  = '0;
    core_rdata = rdata_q;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        for (int i = 0; i < CORES; i++) begin
          core_done[i] = (idx == CORE_ID_W'(i));
        end
        if (!lat_we) begin
          core_rdata = mem_rdata;
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rr_ptr    <= '0;
      idx       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      // The whole request is captured at grant so a core may drop core_req
      // afterwards without affecting the access.
      if (grant) begin
        idx <= pick_idx;
        for (int i = 0; i < CORES; i++) begin
          if (pick_idx == CORE_ID_W'(i)) begin
            lat_we    <= core_we[i];
            lat_addr  <= core_addr[i*WIDTH +: WIDTH];
            lat_wdata <= core_wdata[i*WIDTH +: WIDTH];
          end
        end
      end
      if (state == ST_DONE) begin
        rr_ptr <= (idx == CORE_ID_W'(CORES - 1)) ? '0 : idx + CORE_ID_W'(1);
        if (!lat_we) begin
          rdata_q <= mem_rdata;
        end
      end
    end
  end

endmodule
